pipeline_hazard_ctrl: RTL and testbench

- Central hazard/sequencing controller for the 5-stage MIPS pipeline.
- Drives the `go_one` and `clear` inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB buffers, plus the PC enable and next-PC select.
- Resolves four conditions: memory-not-ready freeze, branch misprediction flush, load-use stall, and syscall halt/resume.
- Keeps saturating stall and flush counters for the debug display.

---
 rtl/pipeline_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard/sequencing control for the 5-stage MIPS pipeline buffers and PC.
module pipeline_hazard_ctrl #(
    parameter int AW    = 12,
    parameter int CW    = 16,
    parameter int DRAIN = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_ready,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          ex_mem_read,
    input  logic [4:0]    ex_rd,
    input  logic          ex_branch,
    input  logic          ex_taken,
    input  logic          ex_p,
    input  logic          ex_halt,
    input  logic [AW-1:0] ex_pc_4,
    input  logic          resume,
    output logic          pc_go,
    output logic [1:0]    pc_sel,
    output logic [AW-1:0] resume_pc,
    output logic          if_id_go,
    output logic          id_ex_go,
    output logic          ex_mem_go,
    output logic          mem_wb_go,
    output logic          if_id_clear,
    output logic          id_ex_clear,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [AW-1:0] resume_pc_q, resume_pc_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic [CW-1:0] flush_cnt_q, flush_cnt_d;
    logic          mispredict, load_use;

    assign mispredict = ex_branch && (ex_taken != ex_p);
    assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        (((ex_rd == id_rs) && id_use_rs) || ((ex_rd == id_rt) && id_use_rt));

    // Outputs are forced to the free-running pattern while rst_n is low.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        resume_pc_d = resume_pc_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_go       = 1'b1;
        pc_sel      = 2'd0;
        if_id_go    = 1'b1;
        id_ex_go    = 1'b1;
        ex_mem_go   = 1'b1;
        mem_wb_go   = 1'b1;
        if_id_clear = 1'b0;
        id_ex_clear = 1'b0;
        halted      = 1'b0;
        if (!rst_n) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            if (!mem_ready) begin
                pc_go     = 1'b0;
                if_id_go  = 1'b0;
                id_ex_go  = 1'b0;
                ex_mem_go = 1'b0;
                mem_wb_go = 1'b0;
            end else if (ex_halt) begin
                pc_go       = 1'b0;
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
                state_d     = S_DRAIN;
                drain_d     = DW'(DRAIN - 1);
                resume_pc_d = ex_pc_4;
            end else if (mispredict) begin
                pc_sel      = 2'd1;
                if_id_clear = 1'b1;
                id_ex_clear = 1'b1;
                flush_cnt_d = (&flush_cnt_q) ? flush_cnt_q : flush_cnt_q + 1'b1;
            end else if (load_use) begin
                pc_go       = 1'b0;
                if_id_go    = 1'b0;
                id_ex_clear = 1'b1;
                stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + 1'b1;
            end
        end else if (state_q == S_DRAIN) begin
            pc_go     = 1'b0;
            if_id_go  = 1'b0;
            id_ex_go  = 1'b0;
            ex_mem_go = mem_ready;
            mem_wb_go = mem_ready;
            if (mem_ready) begin
                state_d = (drain_q == '0) ? S_HALTED : state_q;
                drain_d = (drain_q == '0) ? drain_q : drain_q - 1'b1;
            end
        end else begin
            halted    = 1'b1;
            if_id_go  = 1'b0;
            id_ex_go  = 1'b0;
            ex_mem_go = 1'b0;
            mem_wb_go = 1'b0;
            pc_go     = resume && mem_ready;
            pc_sel    = (resume && mem_ready) ? 2'd2 : 2'd0;
            state_d   = (resume && mem_ready) ? S_RUN : state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            drain_q     <= '0;
            resume_pc_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            resume_pc_q <= resume_pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign resume_pc = resume_pc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench; a narrow-counter copy checks saturation.
module tb_pipeline_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, mem_ready, id_use_rs, id_use_rt, ex_mem_read;
    logic        ex_branch, ex_taken, ex_p, ex_halt, resume;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic [11:0] ex_pc_4;
    logic        pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go, if_id_clear, id_ex_clear, halted;
    logic [1:0]  pc_sel;
    logic [11:0] resume_pc;
    logic [15:0] stall_cnt, flush_cnt;
    logic        s_pc_go, s_if_id_go, s_id_ex_go, s_ex_mem_go, s_mem_wb_go, s_if_id_clear, s_id_ex_clear, s_halted;
    logic [1:0]  s_pc_sel;
    logic [11:0] s_resume_pc;
    logic [2:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_p(ex_p), .ex_halt(ex_halt),
        .ex_pc_4(ex_pc_4), .resume(resume), .pc_go(pc_go), .pc_sel(pc_sel), .resume_pc(resume_pc),
        .if_id_go(if_id_go), .id_ex_go(id_ex_go), .ex_mem_go(ex_mem_go), .mem_wb_go(mem_wb_go),
        .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CW(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch(ex_branch), .ex_taken(ex_taken), .ex_p(ex_p), .ex_halt(ex_halt),
        .ex_pc_4(ex_pc_4), .resume(resume), .pc_go(s_pc_go), .pc_sel(s_pc_sel), .resume_pc(s_resume_pc),
        .if_id_go(s_if_id_go), .id_ex_go(s_id_ex_go), .ex_mem_go(s_ex_mem_go), .mem_wb_go(s_mem_wb_go),
        .if_id_clear(s_if_id_clear), .id_ex_clear(s_id_ex_clear), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        logic        pc_go;
        logic [1:0]  pc_sel;
        logic [11:0] rpc;
        logic [3:0]  go;
        logic [1:0]  clr;
        logic        halted;
        logic [15:0] st;
        logic [15:0] fl;
        logic [2:0]  st3;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    int          ms = 0, md = 0;
    logic [11:0] mrpc = '0;
    logic [15:0] mst = '0, mfl = '0;
    logic [2:0]  mst3 = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 0; md = 0; mrpc = '0; mst = '0; mfl = '0; mst3 = '0;
    endtask

    task automatic step(input logic mr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic lr, input logic [4:0] rd,
                        input logic br, input logic tk, input logic p, input logic hl,
                        input logic [11:0] pc4, input logic res, input string tag);
        exp_t        e, o;
        int          ns, nd;
        logic [11:0] nrpc;
        logic [15:0] nst, nfl;
        logic [2:0]  nst3;
        logic        mis, lu;
        mem_ready = mr; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        ex_mem_read = lr; ex_rd = rd; ex_branch = br; ex_taken = tk; ex_p = p;
        ex_halt = hl; ex_pc_4 = pc4; resume = res;
        e.pc_go = 1'b1; e.pc_sel = 2'd0; e.rpc = mrpc; e.go = 4'hF; e.clr = 2'b00;
        e.halted = 1'b0; e.st = mst; e.fl = mfl; e.st3 = mst3;
        ns = ms; nd = md; nrpc = mrpc; nst = mst; nfl = mfl; nst3 = mst3;
        mis = br && (tk != p);
        lu  = lr && (rd != 5'd0) && (((rd == rs) && urs) || ((rd == rt) && urt));
        if (ms == 0) begin
            if (!mr) begin
                e.pc_go = 1'b0; e.go = 4'h0;
            end else if (hl) begin
                e.pc_go = 1'b0; e.clr = 2'b11; ns = 1; nd = 1; nrpc = pc4;
            end else if (mis) begin
                e.clr = 2'b11; e.pc_sel = 2'd1;
                if (mfl != 16'hFFFF) nfl = mfl + 16'd1;
            end else if (lu) begin
                e.pc_go = 1'b0; e.go = 4'b0111; e.clr = 2'b01;
                if (mst != 16'hFFFF) nst = mst + 16'd1;
                if (mst3 != 3'd7) nst3 = mst3 + 3'd1;
            end
        end else if (ms == 1) begin
            e.pc_go = 1'b0; e.go = {2'b00, mr, mr};
            if (mr) begin
                if (md == 0) ns = 2;
                else nd = md - 1;
            end
        end else begin
            e.halted = 1'b1; e.go = 4'h0; e.pc_go = 1'b0;
            if (res && mr) begin
                e.pc_go = 1'b1; e.pc_sel = 2'd2; ns = 0;
            end
        end
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk({tag, ".pc_go"}, 32'(pc_go), 32'(o.pc_go));
        chk({tag, ".pc_sel"}, 32'(pc_sel), 32'(o.pc_sel));
        chk({tag, ".resume_pc"}, 32'(resume_pc), 32'(o.rpc));
        chk({tag, ".go"}, 32'({if_id_go, id_ex_go, ex_mem_go, mem_wb_go}), 32'(o.go));
        chk({tag, ".clear"}, 32'({if_id_clear, id_ex_clear}), 32'(o.clr));
        chk({tag, ".halted"}, 32'(halted), 32'(o.halted));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(o.st));
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(o.fl));
        chk({tag, ".stall_sat"}, 32'(s_stall_cnt), 32'(o.st3));
        @(posedge clk);
        ms = ns; md = nd; mrpc = nrpc; mst = nst; mfl = nfl; mst3 = nst3;
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 0, tag);
    endtask

    task automatic halt_seq(input logic [11:0] pc4);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, pc4, 0, "halt");
        step(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 1, 12'hFFF, 0, "drain0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 0, "drain_frz");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 1, "drain1");
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b0; id_rs = 5'd3; id_rt = 5'd0; id_use_rs = 1'b1; id_use_rt = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd3; ex_branch = 1'b1; ex_taken = 1'b1; ex_p = 1'b0;
        ex_halt = 1'b1; ex_pc_4 = 12'h123; resume = 1'b1;
        #12;
        chk("rst.go", 32'({pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go}), 32'h1F);
        chk("rst.clear_sel", 32'({if_id_clear, id_ex_clear, pc_sel, halted}), 32'h0);
        chk("rst.regs", 32'({resume_pc, stall_cnt}), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();
        idle(3, "free");
        step(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 12'h0, 0, "lu_rs");
        idle(1, "after_lu");
        step(1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, 12'h0, 0, "lu_rt");
        step(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 12'h0, 0, "lu_r0");
        step(1, 9, 0, 0, 0, 1, 9, 0, 0, 0, 0, 12'h0, 0, "lu_nouse");
        step(1, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 12'h0, 0, "mis_lu");
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 12'h0, 0, "mis_nt");
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 12'h0, 0, "br_ok");
        step(0, 5, 0, 1, 0, 1, 5, 1, 1, 0, 0, 12'h0, 0, "freeze");
        for (int i = 0; i < 8; i++) step(1, 4, 0, 1, 0, 1, 4, 0, 0, 0, 0, 12'h0, 0, "lu_sat");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 1, "res_run");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h055, 0, "halt_frz");
        halt_seq(12'h03C);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 12'h0, 0, "halted");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 1, "res_held");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 0, "still_halt");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'h0, 1, "resume");
        idle(2, "run_again");
        halt_seq(12'h2A8);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.halted", 32'(halted), 32'h0);
        chk("arst.resume_pc", 32'(resume_pc), 32'h0);
        chk("arst.go", 32'({pc_go, if_id_go, id_ex_go, ex_mem_go, mem_wb_go}), 32'h1F);
        chk("arst.cnt", 32'({stall_cnt, flush_cnt}), 32'h0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2, "post_rst");
        step(1, 6, 0, 1, 0, 1, 6, 0, 0, 0, 0, 12'h0, 0, "lu_post");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
